ram8_clear: RTL and testbench

Eight-word, 16-bit register-file memory with a sequenced bulk-clear engine. It sits directly downstream of the 1-bit load register stage: each storage word is a bank of load-enabled bits, addressed by a decoder. It adds a multi-cycle clear operation with a busy/done handshake so the datapath can zero all words without issuing DEPTH separate writes.

---
 rtl/ram8_pkg.sv | 15 +
 rtl/ram8_clear_register16.sv | 37 +++
 rtl/ram8_clear.sv | 105 ++++++++++
 tb/tb_ram8_clear.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ram8_pkg.sv
// Shared definitions for the eight-word memory with bulk-clear engine.
package ram8_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 8;

  // Clear sequencer states: idle/normal access, clear walking the words,
  // and a single-cycle completion state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clear_state_e;

endpackage

// File: rtl/ram8_clear_register16.sv
// One storage word: a bank of load-enabled bits with a synchronous zero input.
module register16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next value: zeroing wins over a load so a clear step can never be undone.
  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = d;
    end
  end

  // Word storage, forced to zero while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ram8_clear.sv
// Eight-word register-file memory with a sequenced bulk-clear engine.
// Holds the address decoder, read mux, clear FSM and clear index counter.
module ram8_clear
  import ram8_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear_start,
  output logic [WIDTH-1:0]  out,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              write_drop
);

  clear_state_e      state_d;
  clear_state_e      state_q;
  logic [ADDR_W-1:0] idx_d;
  logic [ADDR_W-1:0] idx_q;

  logic [DEPTH-1:0]  word_load;
  logic [DEPTH-1:0]  word_clear;
  logic [WIDTH-1:0]  word_q [DEPTH];

  // Storage array: every word sees the shared write data, selected by the decoder.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    register16 #(
      .WIDTH(WIDTH)
    ) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (word_load[g]),
      .clear (word_clear[g]),
      .d     (in),
      .q     (word_q[g])
    );
  end

  // Sequencer next-state, index stepping and per-word write/zero decode.
  // Writes are decoded in IDLE and DONE only; CLEAR zeroes one word per edge.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_load  = '0;
    word_clear = '0;
    case (state_q)
      IDLE: begin
        if (load) begin
          word_load[address] = 1'b1;
        end
        if (clear_start) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        word_clear[idx_q] = 1'b1;
        idx_d             = idx_q + 1'b1;
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (load) begin
          word_load[address] = 1'b1;
        end
        if (clear_start) begin
          state_d = CLEAR;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Sequencer state and index registers; reset aborts any clear in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Status is decoded straight from the state register; the drop flag also
  // looks at load so it flags the suppressed write in the cycle it is offered.
  assign clear_busy = (state_q == CLEAR);
  assign clear_done = (state_q == DONE);
  assign write_drop = (state_q == CLEAR) && load;
  assign out        = word_q[address];

endmodule

// File: tb/tb_ram8_clear.sv
// Self-checking bench for ram8_clear: behavioural memory model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ram8_clear;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clear_start;
  logic [15:0] out;
  logic        clear_busy;
  logic        clear_done;
  logic        write_drop;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: the memory contents plus "how many words are still to
  // be zeroed" and a flag for the completion cycle.
  logic [15:0] m_mem [8];
  int          m_remaining;
  bit          m_done;

  logic seen_busy;
  logic seen_done;
  logic seen_drop;

  ram8_clear dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in),
    .load        (load),
    .address     (address),
    .clear_start (clear_start),
    .out         (out),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .write_drop  (write_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_mem[k] = 16'h0000;
    m_remaining = 0;
    m_done      = 1'b0;
  endtask

  // One rising edge as seen by the model: while words remain to be zeroed the
  // next one in ascending order is cleared and writes are ignored.
  task automatic model_edge();
    if (m_remaining > 0) begin
      m_mem[8 - m_remaining] = 16'h0000;
      m_remaining--;
      m_done = (m_remaining == 0);
    end else begin
      if (load) m_mem[address] = in;
      m_done = 1'b0;
      if (clear_start) m_remaining = 8;
    end
  endtask

  // Compare all DUT outputs against the model at mid-cycle.
  task automatic compare_all();
    check("out",        out,        m_mem[address]);
    check("clear_busy", 16'(clear_busy), 16'(m_remaining > 0));
    check("clear_done", 16'(clear_done), 16'(m_done));
    check("write_drop", 16'(write_drop), 16'((m_remaining > 0) && load));
    seen_busy = clear_busy;
    seen_done = clear_done;
    seen_drop = write_drop;
  endtask

  task automatic applyStimulus(input logic ld, input logic cs, input logic [2:0] a, input logic [15:0] d);
    load        = ld;
    clear_start = cs;
    address     = a;
    in          = d;
  endtask

  // One full clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic checkOutput(input logic [2:0] a, input logic [15:0] exp, input string name);
    load        = 1'b0;
    clear_start = 1'b0;
    address     = a;
    #1;
    check(name, out, exp);
  endtask

  initial begin
    int busy_cnt;
    int done_at;
    int done_cnt;

    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
    rst_n = 1'b0;
    model_reset();
    #3;
    for (int a = 0; a < 8; a++) checkOutput(3'(a), 16'h0000, "reset_out");
    check("reset_busy", 16'(clear_busy), 16'h0);
    check("reset_done", 16'(clear_done), 16'h0);
    check("reset_drop", 16'(write_drop), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b0, 1'b0, 3'(a), 16'h0000);
      cycle();
    end

    // Write / read back.
    applyStimulus(1'b1, 1'b0, 3'd3, 16'hBEEF);
    cycle();
    applyStimulus(1'b1, 1'b0, 3'd7, 16'h1234);
    cycle();
    checkOutput(3'd3, 16'hBEEF, "read_w3");
    checkOutput(3'd7, 16'h1234, "read_w7");
    checkOutput(3'd0, 16'h0000, "read_w0");

    // Fill, then bulk clear with a dropped write in the fourth busy cycle.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 3'(k), 16'(16'h1111 * (k + 1)));
      cycle();
    end
    applyStimulus(1'b0, 1'b1, 3'd0, 16'h0000);
    cycle();
    busy_cnt = 0;
    done_at  = -1;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) applyStimulus(1'b1, 1'b0, 3'd2, 16'hAAAA);
      else        applyStimulus(1'b0, 1'b0, 3'(i), 16'h0000);
      cycle();
      if (seen_busy) busy_cnt++;
      if (seen_done) done_at = i;
      if (i == 3) check("drop_in_busy4", 16'(seen_drop), 16'h1);
    end
    check("busy_cycles", 16'(busy_cnt), 16'd8);
    check("done_cycle", 16'(done_at), 16'd8);
    checkOutput(3'd2, 16'h0000, "dropped_w2");
    checkOutput(3'd7, 16'h0000, "cleared_w7");

    // Simultaneous write + start, then back-to-back clear from DONE.
    applyStimulus(1'b1, 1'b1, 3'd5, 16'h5555);
    cycle();
    checkOutput(3'd5, 16'h5555, "simul_w5");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd5, 16'h0000);
      cycle();
    end
    applyStimulus(1'b0, 1'b1, 3'd5, 16'h0000);
    cycle();
    check("done_before_b2b", 16'(seen_done), 16'h1);
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 3'(i), 16'h0000);
      cycle();
      if (seen_busy) busy_cnt++;
    end
    check("b2b_busy_cycles", 16'(busy_cnt), 16'd8);
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
    cycle();
    check("b2b_done", 16'(seen_done), 16'h1);

    // Reset in the fourth busy cycle.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 3'(k), 16'(16'hA5A0 + k));
      cycle();
    end
    applyStimulus(1'b0, 1'b1, 3'd6, 16'h0000);
    cycle();
    applyStimulus(1'b0, 1'b0, 3'd6, 16'h0000);
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_busy", 16'(clear_busy), 16'h0);
    check("abort_done", 16'(clear_done), 16'h0);
    check("abort_drop", 16'(write_drop), 16'h0);
    for (int a = 0; a < 8; a++) checkOutput(3'(a), 16'h0000, "abort_out");
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 3'(i), 16'h0000);
      cycle();
      if (seen_done) done_cnt++;
    end
    check("no_done_after_abort", 16'(done_cnt), 16'h0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                    3'($urandom_range(0, 7)), 16'($urandom));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
